// File: rtl/link_align_ctrl.sv
// Per-lane word-alignment controller for the 4-lane 20-bit PCS receive path.
// Sweeps each aligner's slip offset until the sync word is found, then verifies and holds lock.
module link_align_ctrl #(
  parameter logic [19:0] SYNC_WORD  = 20'hF3C0A,
  parameter logic [15:0] FRAME_LEN  = 16'd1024,
  parameter logic [15:0] WAIT_CYC   = 16'd64,
  parameter logic [3:0]  LOCK_CNT   = 4'd4,
  parameter logic [3:0]  LOSS_CNT   = 4'd3,
  parameter logic [3:0]  MAX_ROUNDS = 4'd4
) (
  input  logic        iSclk,
  input  logic        iRstN,
  input  logic        iResync,
  input  logic [19:0] iD_Link1,
  input  logic [19:0] iD_Link2,
  input  logic [19:0] iD_Link3,
  input  logic [19:0] iD_Link4,
  output logic [2:0]  oSlip1,
  output logic [2:0]  oSlip2,
  output logic [2:0]  oSlip3,
  output logic [2:0]  oSlip4,
  output logic [3:0]  oSlipPulse,
  output logic [3:0]  oLock,
  output logic        oAllLock,
  output logic [3:0]  oFail,
  output logic        oRst
);

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_SEARCH,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  state_t      st_q   [4];
  state_t      st_d   [4];
  logic [15:0] cnt_q  [4];
  logic [15:0] cnt_d  [4];
  logic [15:0] fcnt_q [4];
  logic [15:0] fcnt_d [4];
  logic [3:0]  hm_q   [4];
  logic [3:0]  hm_d   [4];
  logic [3:0]  rnd_q  [4];
  logic [3:0]  rnd_d  [4];
  logic [2:0]  slip_q [4];
  logic [2:0]  slip_d [4];
  logic [3:0]  lock_q, lock_d;
  logic [3:0]  fail_q, fail_d;
  logic [3:0]  pulse_q, pulse_d;
  logic        all_lock_q, all_lock_d;
  logic        rst_q, rst_d;
  logic [19:0] link [4];
  logic [3:0]  hit;
  logic [3:0]  slip_ev;

  assign link[0] = iD_Link1;
  assign link[1] = iD_Link2;
  assign link[2] = iD_Link3;
  assign link[3] = iD_Link4;

  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      hit[i] = (link[i] == SYNC_WORD);
    end
  end

  always_comb begin
    lock_d  = lock_q;
    fail_d  = fail_q;
    pulse_d = '0;
    slip_ev = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      st_d[i]   = st_q[i];
      cnt_d[i]  = cnt_q[i];
      fcnt_d[i] = fcnt_q[i];
      hm_d[i]   = hm_q[i];
      rnd_d[i]  = rnd_q[i];
      slip_d[i] = slip_q[i];

      case (st_q[i])
        ST_SETTLE: begin
          if (cnt_q[i] == WAIT_CYC - 16'd1) begin
            st_d[i]  = ST_SEARCH;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 16'd1;
          end
        end
        ST_SEARCH: begin
          // A hit on the last window cycle still counts; it beats the slip.
          if (hit[i]) begin
            st_d[i]   = ST_VERIFY;
            fcnt_d[i] = 16'd1;
            hm_d[i]   = '0;
          end else if (cnt_q[i] == FRAME_LEN - 16'd1) begin
            slip_ev[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 16'd1;
          end
        end
        ST_VERIFY: begin
          fcnt_d[i] = (fcnt_q[i] == FRAME_LEN - 16'd1) ? '0 : fcnt_q[i] + 16'd1;
          if (fcnt_q[i] == '0) begin
            if (hit[i]) begin
              hm_d[i] = hm_q[i] + 4'd1;
              if (hm_q[i] + 4'd1 == LOCK_CNT) begin
                st_d[i]   = ST_LOCKED;
                hm_d[i]   = '0;
                rnd_d[i]  = '0;
                lock_d[i] = 1'b1;
              end
            end else begin
              slip_ev[i] = 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          fcnt_d[i] = (fcnt_q[i] == FRAME_LEN - 16'd1) ? '0 : fcnt_q[i] + 16'd1;
          if (fcnt_q[i] == '0) begin
            if (hit[i]) begin
              hm_d[i] = '0;
            end else if (hm_q[i] + 4'd1 == LOSS_CNT) begin
              st_d[i]   = ST_SEARCH;
              cnt_d[i]  = '0;
              hm_d[i]   = '0;
              lock_d[i] = 1'b0;
            end else begin
              hm_d[i] = hm_q[i] + 4'd1;
            end
          end
        end
        default: st_d[i] = ST_SETTLE;
      endcase

      if (slip_ev[i]) begin
        st_d[i]    = ST_SETTLE;
        cnt_d[i]   = '0;
        pulse_d[i] = 1'b1;
        if (slip_q[i] == 3'd4) begin
          slip_d[i] = '0;
          rnd_d[i]  = (rnd_q[i] == 4'hF) ? 4'hF : rnd_q[i] + 4'd1;
          if (rnd_d[i] >= MAX_ROUNDS) begin
            fail_d[i] = 1'b1;
          end
        end else begin
          slip_d[i] = slip_q[i] + 3'd1;
        end
      end

      // Resync overrides whatever the lane decided this cycle.
      if (iResync) begin
        st_d[i]    = ST_SETTLE;
        cnt_d[i]   = '0;
        fcnt_d[i]  = '0;
        hm_d[i]    = '0;
        rnd_d[i]   = '0;
        slip_d[i]  = '0;
        lock_d[i]  = 1'b0;
        fail_d[i]  = 1'b0;
        pulse_d[i] = (slip_q[i] != 3'd0);
      end
    end
    all_lock_d = &lock_q;
    rst_d      = |pulse_q;
  end

  always_ff @(posedge iSclk or negedge iRstN) begin
    if (!iRstN) begin
      for (int unsigned i = 0; i < 4; i++) begin
        st_q[i]   <= ST_SETTLE;
        cnt_q[i]  <= '0;
        fcnt_q[i] <= '0;
        hm_q[i]   <= '0;
        rnd_q[i]  <= '0;
        slip_q[i] <= '0;
      end
      lock_q     <= '0;
      fail_q     <= '0;
      pulse_q    <= '0;
      all_lock_q <= 1'b0;
      rst_q      <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        st_q[i]   <= st_d[i];
        cnt_q[i]  <= cnt_d[i];
        fcnt_q[i] <= fcnt_d[i];
        hm_q[i]   <= hm_d[i];
        rnd_q[i]  <= rnd_d[i];
        slip_q[i] <= slip_d[i];
      end
      lock_q     <= lock_d;
      fail_q     <= fail_d;
      pulse_q    <= pulse_d;
      all_lock_q <= all_lock_d;
      rst_q      <= rst_d;
    end
  end

  assign oSlip1     = slip_q[0];
  assign oSlip2     = slip_q[1];
  assign oSlip3     = slip_q[2];
  assign oSlip4     = slip_q[3];
  assign oSlipPulse = pulse_q;
  assign oLock      = lock_q;
  assign oAllLock   = all_lock_q;
  assign oFail      = fail_q;
  assign oRst       = rst_q;

endmodule

// File: tb/tb_link_align_ctrl.sv
// Bench for link_align_ctrl: an aligner model feeds sync words per lane offset/phase,
// slip pulses are scoreboarded against expected (cycle, offset) events.
module tb_link_align_ctrl;

  localparam logic [19:0] SYNC = 20'hF3C0A;
  localparam int FRAME = 16;

  logic        iSclk = 1'b0;
  logic        iRstN, iResync;
  logic [19:0] iD_Link1, iD_Link2, iD_Link3, iD_Link4;
  logic [2:0]  oSlip1, oSlip2, oSlip3, oSlip4;
  logic [3:0]  oSlipPulse, oLock, oFail;
  logic        oAllLock, oRst;

  link_align_ctrl #(
    .SYNC_WORD (SYNC),
    .FRAME_LEN (16'd16),
    .WAIT_CYC  (16'd8),
    .LOCK_CNT  (4'd3),
    .LOSS_CNT  (4'd2),
    .MAX_ROUNDS(4'd2)
  ) dut (
    .iSclk(iSclk), .iRstN(iRstN), .iResync(iResync),
    .iD_Link1(iD_Link1), .iD_Link2(iD_Link2), .iD_Link3(iD_Link3), .iD_Link4(iD_Link4),
    .oSlip1(oSlip1), .oSlip2(oSlip2), .oSlip3(oSlip3), .oSlip4(oSlip4),
    .oSlipPulse(oSlipPulse), .oLock(oLock), .oAllLock(oAllLock), .oFail(oFail), .oRst(oRst)
  );

  always #5 iSclk = ~iSclk;

  typedef struct {
    int         lane;
    int         cyc;
    logic [2:0] slip;
  } ev_t;

  ev_t        sb[$];
  int         drop_k[$];
  int         extra_k[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         en [4];
  logic [2:0] tgt [4];
  int         ph [4];
  logic [3:0] mon_mask = '0;

  function automatic logic [2:0] get_slip(int i);
    case (i)
      0: return oSlip1;
      1: return oSlip2;
      2: return oSlip3;
      default: return oSlip4;
    endcase
  endfunction

  function automatic bit is_drop(int key);
    foreach (drop_k[j]) if (drop_k[j] == key) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_extra(int key);
    foreach (extra_k[j]) if (extra_k[j] == key) return 1'b1;
    return 1'b0;
  endfunction

  // Non-sync filler, sometimes one bit away from the sync word.
  function automatic logic [19:0] filler();
    logic [19:0] w;
    w = 20'($urandom);
    if (w == SYNC) w = ~w;
    if ($urandom_range(0, 3) == 0) w = SYNC ^ (20'd1 << $urandom_range(0, 19));
    return w;
  endfunction

  function automatic logic [19:0] lane_data(int i);
    int key = cyc * 4 + i;
    bit show;
    show = en[i] && (get_slip(i) == tgt[i]) &&
           ((((cyc % FRAME) == ph[i]) && !is_drop(key)) || is_extra(key));
    return show ? SYNC : filler();
  endfunction

  function automatic int first_hit(int start, int phase);
    int c = start;
    while ((c % FRAME) != phase) c++;
    return c;
  endfunction

  task automatic step();
    @(posedge iSclk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (mon_mask[i] && oSlipPulse[i]) begin
        int idx = -1;
        foreach (sb[j]) if (idx < 0 && sb[j].lane == i) idx = j;
        checks++;
        if (idx < 0) begin
          errors++;
          $display("FAIL slip_pulse lane%0d: got pulse at cycle %0d slip %0d, expected none", i + 1, cyc, get_slip(i));
        end else begin
          if (sb[idx].cyc !== cyc || sb[idx].slip !== get_slip(i)) begin
            errors++;
            $display("FAIL slip_pulse lane%0d: got cycle %0d slip %0d, expected cycle %0d slip %0d",
                     i + 1, cyc, get_slip(i), sb[idx].cyc, sb[idx].slip);
          end
          sb.delete(idx);
        end
      end
    end
    iD_Link1 = lane_data(0);
    iD_Link2 = lane_data(1);
    iD_Link3 = lane_data(2);
    iD_Link4 = lane_data(3);
  endtask

  task automatic run_until(int c);
    while (cyc < c) step();
  endtask

  task automatic push_ev(int lane, int c, logic [2:0] s);
    ev_t e;
    e.lane = lane;
    e.cyc  = c;
    e.slip = s;
    sb.push_back(e);
  endtask

  task automatic cfg(int i, bit e, logic [2:0] t, int p);
    en[i]  = e;
    tgt[i] = t;
    ph[i]  = p;
  endtask

  task automatic apply_reset();
    iResync  = 1'b0;
    mon_mask = '0;
    sb.delete();
    drop_k.delete();
    extra_k.delete();
    iRstN = 1'b0;
    step();
    step();
    iRstN = 1'b1;
  endtask

  task automatic test_reset();
    int r;
    for (int i = 0; i < 4; i++) cfg(i, 1'b0, 3'd0, 0);
    iRstN = 1'b0; iResync = 1'b0;
    iD_Link1 = '0; iD_Link2 = '0; iD_Link3 = '0; iD_Link4 = '0;
    #1;
    checks++;
    if ({oSlip1, oSlip2, oSlip3, oSlip4, oSlipPulse, oLock, oAllLock, oFail, oRst} !== 30'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {oSlip1, oSlip2, oSlip3, oSlip4, oSlipPulse, oLock, oAllLock, oFail, oRst});
    end
    apply_reset();
    r = cyc;
    // With no sync, lane 1 settles 8 cycles, searches 16, then slips.
    mon_mask = 4'b0001;
    push_ev(0, r + 24, 3'd1);
    run_until(r + 30);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL reset_first_slip: got %0d pending events expected 0", sb.size());
    end
  endtask

  task automatic test_lane1_lock();
    int r, t;
    for (int i = 0; i < 4; i++) cfg(i, 1'b0, 3'd0, 0);
    cfg(0, 1'b1, 3'd0, 5);
    apply_reset();
    r = cyc;
    mon_mask = 4'b0001;
    t = first_hit(r + 8, 5);
    run_until(t + 48);
    checks++;
    if (oLock[0] !== 1'b0) begin errors++; $display("FAIL lane1_lock_early: got %b expected 0", oLock[0]); end
    step();
    checks++;
    if (oLock[0] !== 1'b1) begin errors++; $display("FAIL lane1_lock: got %b expected 1", oLock[0]); end
    checks++;
    if (oSlip1 !== 3'd0) begin errors++; $display("FAIL lane1_slip: got %0d expected 0", oSlip1); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL lane1_pending: got %0d expected 0", sb.size()); end
  endtask

  task automatic test_lane2_slip();
    int r, t;
    bit prev;
    for (int i = 0; i < 4; i++) cfg(i, 1'b0, 3'd0, 0);
    cfg(1, 1'b1, 3'd3, 9);
    apply_reset();
    r = cyc;
    mon_mask = 4'b0010;
    push_ev(1, r + 24, 3'd1);
    push_ev(1, r + 48, 3'd2);
    push_ev(1, r + 72, 3'd3);
    t = first_hit(r + 80, 9);
    while (cyc < t + 48) begin
      prev = oSlipPulse[1];
      step();
      if (prev) begin
        checks++;
        if (oRst !== 1'b1) begin errors++; $display("FAIL lane2_rst: got %b expected 1 at cycle %0d", oRst, cyc); end
      end
    end
    checks++;
    if (oLock[1] !== 1'b0) begin errors++; $display("FAIL lane2_lock_early: got %b expected 0", oLock[1]); end
    step();
    checks++;
    if (oLock[1] !== 1'b1) begin errors++; $display("FAIL lane2_lock: got %b expected 1", oLock[1]); end
    checks++;
    if (oSlip2 !== 3'd3) begin errors++; $display("FAIL lane2_slip: got %0d expected 3", oSlip2); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL lane2_pending: got %0d expected 0", sb.size()); end
  endtask

  task automatic test_lane3_fail();
    int r;
    bit lock_seen = 1'b0;
    for (int i = 0; i < 4; i++) cfg(i, 1'b0, 3'd0, 0);
    apply_reset();
    r = cyc;
    mon_mask = 4'b0100;
    for (int k = 1; k <= 12; k++) push_ev(2, r + 24 * k, 3'(k % 5));
    while (cyc < r + 239) begin
      step();
      if (oLock[2] !== 1'b0) lock_seen = 1'b1;
    end
    checks++;
    if (oFail[2] !== 1'b0) begin errors++; $display("FAIL lane3_fail_early: got %b expected 0", oFail[2]); end
    step();
    checks++;
    if (oFail[2] !== 1'b1) begin errors++; $display("FAIL lane3_fail: got %b expected 1", oFail[2]); end
    while (cyc < r + 290) begin
      step();
      if (oLock[2] !== 1'b0) lock_seen = 1'b1;
    end
    checks++;
    if (lock_seen) begin errors++; $display("FAIL lane3_lock: got 1 expected 0"); end
    checks++;
    if (oFail[2] !== 1'b1) begin errors++; $display("FAIL lane3_fail_sticky: got %b expected 1", oFail[2]); end
    push_ev(2, cyc + 1, 3'd0);
    iResync = 1'b1;
    step();
    iResync = 1'b0;
    checks++;
    if (oFail[2] !== 1'b0) begin errors++; $display("FAIL lane3_resync_fail: got %b expected 0", oFail[2]); end
    checks++;
    if (oSlip3 !== 3'd0) begin errors++; $display("FAIL lane3_resync_slip: got %0d expected 0", oSlip3); end
    mon_mask = '0;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL lane3_pending: got %0d expected 0", sb.size()); end
  endtask

  task automatic test_lane4_loss();
    int r, t;
    bit held = 1'b1;
    for (int i = 0; i < 4; i++) cfg(i, 1'b0, 3'd0, 0);
    cfg(3, 1'b1, 3'd0, 3);
    apply_reset();
    r = cyc;
    mon_mask = 4'b1000;
    t = first_hit(r + 8, 3);
    drop_k.push_back((t + 64) * 4 + 3);
    drop_k.push_back((t + 96) * 4 + 3);
    drop_k.push_back((t + 112) * 4 + 3);
    // Off-phase sync words while locked must not rescue the frame.
    extra_k.push_back((t + 70) * 4 + 3);
    extra_k.push_back((t + 100) * 4 + 3);
    run_until(t + 48);
    checks++;
    if (oLock[3] !== 1'b0) begin errors++; $display("FAIL lane4_lock_early: got %b expected 0", oLock[3]); end
    step();
    checks++;
    if (oLock[3] !== 1'b1) begin errors++; $display("FAIL lane4_lock: got %b expected 1", oLock[3]); end
    while (cyc < t + 112) begin
      step();
      if (oLock[3] !== 1'b1) held = 1'b0;
    end
    checks++;
    if (!held) begin errors++; $display("FAIL lane4_single_miss: got 0 expected 1"); end
    step();
    checks++;
    if (oLock[3] !== 1'b0) begin errors++; $display("FAIL lane4_loss: got %b expected 0", oLock[3]); end
    run_until(t + 176);
    checks++;
    if (oLock[3] !== 1'b0) begin errors++; $display("FAIL lane4_relock_early: got %b expected 0", oLock[3]); end
    step();
    checks++;
    if (oLock[3] !== 1'b1) begin errors++; $display("FAIL lane4_relock: got %b expected 1", oLock[3]); end
    checks++;
    if (oSlip4 !== 3'd0) begin errors++; $display("FAIL lane4_slip: got %0d expected 0", oSlip4); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL lane4_pending: got %0d expected 0", sb.size()); end
  endtask

  task automatic test_all_lock_resync();
    int r, l, t;
    cfg(0, 1'b1, 3'd0, 2);
    cfg(1, 1'b1, 3'd2, 7);
    cfg(2, 1'b1, 3'd0, 11);
    cfg(3, 1'b1, 3'd0, 14);
    apply_reset();
    r = cyc;
    mon_mask = 4'b1111;
    push_ev(1, r + 24, 3'd1);
    push_ev(1, r + 48, 3'd2);
    l = first_hit(r + 56, 7);
    t = first_hit(r + 8, 2);  if (t > l) l = t;
    t = first_hit(r + 8, 11); if (t > l) l = t;
    t = first_hit(r + 8, 14); if (t > l) l = t;
    l = l + 49;
    run_until(l);
    checks++;
    if (oLock !== 4'hF) begin errors++; $display("FAIL all_lock: got %h expected f", oLock); end
    checks++;
    if (oAllLock !== 1'b0) begin errors++; $display("FAIL all_lock_lag: got %b expected 0", oAllLock); end
    step();
    checks++;
    if (oAllLock !== 1'b1) begin errors++; $display("FAIL all_lock_set: got %b expected 1", oAllLock); end
    run_until(l + 3);
    push_ev(1, cyc + 1, 3'd0);
    iResync = 1'b1;
    step();
    iResync = 1'b0;
    checks++;
    if (oSlip2 !== 3'd0) begin errors++; $display("FAIL resync_slip2: got %0d expected 0", oSlip2); end
    checks++;
    if (oSlipPulse !== 4'b0010) begin errors++; $display("FAIL resync_pulse: got %b expected 0010", oSlipPulse); end
    checks++;
    if (oLock !== 4'h0 || oFail !== 4'h0) begin
      errors++;
      $display("FAIL resync_lock_fail: got lock %h fail %h expected 0 0", oLock, oFail);
    end
    checks++;
    if (oAllLock !== 1'b1) begin errors++; $display("FAIL resync_alllock_lag: got %b expected 1", oAllLock); end
    step();
    checks++;
    if (oAllLock !== 1'b0 || oRst !== 1'b1) begin
      errors++;
      $display("FAIL resync_alllock_rst: got alllock %b rst %b expected 0 1", oAllLock, oRst);
    end
    mon_mask = '0;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL resync_pending: got %0d expected 0", sb.size()); end
  endtask

  task automatic test_reset_mid_verify();
    int r, t, r2;
    for (int i = 0; i < 4; i++) cfg(i, 1'b0, 3'd0, 0);
    cfg(0, 1'b1, 3'd0, 4);
    cfg(1, 1'b1, 3'd3, 6);
    apply_reset();
    r = cyc;
    mon_mask = 4'b0010;
    push_ev(1, r + 24, 3'd1);
    push_ev(1, r + 48, 3'd2);
    push_ev(1, r + 72, 3'd3);
    t = first_hit(r + 80, 6);
    run_until(t + 20);
    mon_mask = '0;
    checks++;
    if (oSlip2 !== 3'd3 || oLock[0] !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL midverify_pre: got slip2 %0d lock0 %b pending %0d expected 3 1 0", oSlip2, oLock[0], sb.size());
    end
    iRstN = 1'b0;
    #1;
    checks++;
    if ({oSlip1, oSlip2, oSlip3, oSlip4, oSlipPulse, oLock, oAllLock, oFail, oRst} !== 30'd0) begin
      errors++;
      $display("FAIL midverify_reset: got %h expected 0",
               {oSlip1, oSlip2, oSlip3, oSlip4, oSlipPulse, oLock, oAllLock, oFail, oRst});
    end
    step();
    while ((cyc % FRAME) != 1) step();
    iRstN = 1'b1;
    r2 = cyc;
    // A sync word lands at r2+3, inside the settle period, and must be ignored.
    t = first_hit(r2 + 8, 4);
    run_until(t + 48);
    checks++;
    if (oLock[0] !== 1'b0) begin errors++; $display("FAIL postreset_lock_early: got %b expected 0", oLock[0]); end
    step();
    checks++;
    if (oLock[0] !== 1'b1) begin errors++; $display("FAIL postreset_lock: got %b expected 1", oLock[0]); end
  endtask

  initial begin
    test_reset();
    test_lane1_lock();
    test_lane2_slip();
    test_lane3_fail();
    test_lane4_loss();
    test_all_lock_resync();
    test_reset_mid_verify();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/link_align_ctrl.md
# link_align_ctrl

Per-lane word-alignment controller for the 4-lane, 20-bit PCS receive path. It drives the slip offset (0..4) of each lane's word aligner and watches that lane's aligned output for a periodic sync word. It stops slipping once the sync word is found and declares lock after repeated confirmation. It reports lock/fail status to the link layer and issues a one-cycle reset pulse to downstream logic on every offset change.

## Interface
- SYNC_WORD, 20'hF3C0A, sync marker expected once per frame on each aligned lane
- FRAME_LEN, 16'd1024, frame period in cycles (2..65535)
- WAIT_CYC, 16'd64, settle cycles after any offset change (1..65535)
- LOCK_CNT, 4'd4, consecutive on-time hits required for lock (1..15)
- LOSS_CNT, 4'd3, consecutive misses that drop lock (1..15)
- MAX_ROUNDS, 4'd4, full offset sweeps (5 slips each) without lock before fail is flagged (1..15)
- iSclk  in  1  clock; one clock domain
- iRstN  in  1  asynchronous active-low reset
- iResync  in  1  synchronous restart of all lanes, highest priority
- iD_Link1..iD_Link4  in  20 each  aligned words from the aligner, lanes 1..4
- oSlip1..oSlip4  out  3 each  slip offset to the aligner, range 0..4
- oSlipPulse  out  4  bit n-1 high for one cycle when oSlipn changes
- oLock  out  4  per-lane lock
- oAllLock  out  1  all four lanes locked (registered AND of oLock)
- oFail  out  4  sticky per-lane "MAX_ROUNDS sweeps without lock"
- oRst  out  1  OR of oSlipPulse bits, registered; downstream flush request

## Operation
- Four identical, independent lane FSMs. Each lane has a wait/window counter (16b), a frame counter fcnt (16b, 0..FRAME_LEN-1), a hit/miss counter (4b), a slip counter (0..4), and a round counter (4b).
- hit: the current-cycle iD_Link equals SYNC_WORD (combinational compare on the sampled input).
- SETTLE: count WAIT_CYC cycles. Then go to SEARCH with the window counter at 0.
- SEARCH: a window of FRAME_LEN cycles.
  - hit: go to VERIFY with fcnt=1 and good=0.
  - No hit by the end of the window: slip, then SETTLE.
- slip: oSlip = (oSlip==4) ? 0 : oSlip+1, and oSlipPulse fires in the same cycle.
  - On the 4→0 wrap, the round counter increments.
  - When the round counter reaches MAX_ROUNDS, oFail is set. Searching continues.
- VERIFY: fcnt increments and wraps at FRAME_LEN-1. The lane is checked only when fcnt==0.
  - hit: good+1. When good reaches LOCK_CNT, go to LOCKED and set oLock.
  - miss: slip, then SETTLE.
- LOCKED: checked only when fcnt==0.
  - hit: miss count cleared.
  - miss: miss count +1. When it reaches LOSS_CNT, oLock is cleared and the lane goes to SEARCH. The offset is kept (no slip) and the window counter is set to 0.
- Entering LOCKED clears the round counter. oFail is not cleared.
- iResync: every lane goes to SETTLE.
  - oSlip=0 and all counters are set to 0.
  - oLock=0 and oFail=0.
  - oSlipPulse fires only for lanes whose oSlip was nonzero.
- A hit outside fcnt==0 in VERIFY/LOCKED is ignored.

## Timing
- Reset values (async):
  - oSlip1..4=0; oSlipPulse=0; oLock=0; oAllLock=0; oFail=0; oRst=0.
  - Every lane is in SETTLE with its counter at 0.
- oSlip, oSlipPulse, oLock and oFail are registered. They change on the clock edge that ends the deciding cycle.
- oAllLock and oRst lag oLock/oSlipPulse by one cycle.
- SEARCH hit at cycle t:
  - Checks occur at t+k·FRAME_LEN.
  - With all checks hitting, oLock rises at t+LOCK_CNT·FRAME_LEN+1.
- Minimum spacing between failed slips: WAIT_CYC+FRAME_LEN cycles.
- iResync wins over any simultaneous slip, lock, or loss event in the same cycle.
- The aligner applies a new offset after its own pipeline. WAIT_CYC must exceed that latency; this is an integration rule, not checked by the block.

## Test plan
Parameters for all scenarios: FRAME_LEN=16, WAIT_CYC=8, LOCK_CNT=3, LOSS_CNT=2, MAX_ROUNDS=2.
- Lane 1 shows SYNC_WORD every 16 cycles at offset 0, first hit at t → oLock[0] high at t+49, no slip pulses, oSlip1=0.
- Lane 2 shows sync only when oSlip2==3 → three oSlipPulse[1] pulses 24 cycles apart, oSlip2 steps 0→1→2→3, then lock; oRst follows each pulse by one cycle.
- Lane 3 never shows sync → oSlip3 sequence 0,1,2,3,4,0,… with oFail[2] set on the 10th slip; slipping continues; oLock[2] stays 0.
- Lane 4 locked, then one missed frame followed by hits → oLock stays 1. Two consecutive misses → oLock[3] falls, no slip, oSlip4 unchanged, relocks after 3 frames once sync returns.
- All lanes locked → oAllLock 1 one cycle after the last oLock. iResync while lane 2 has oSlip=2 → next edge oSlip2=0, oSlipPulse[1]=1, oLock=0, oFail=0, oAllLock 0 a cycle later.
- iRstN asserted mid-VERIFY → all outputs 0 immediately. After release, lanes wait WAIT_CYC before searching.
